peripheral_clock_responder: RTL and testbench

PERIPHERAL_CLOCK_RESPONDER -- requirements
Module: peripheral_clock_responder

---
 rtl/peripheral_clock_responder.sv | 112 +++++++++++
 tb/tb_peripheral_clock_responder.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/peripheral_clock_responder.sv
// rtl/peripheral_clock_responder.sv - peripheral clock-gate enable/drain sequencer
// Optional drain timeout enabled by PERIPHERAL_CLOCK_RESPONDER_DRAIN_TIMEOUT_EN.
module peripheral_clock_responder #(
  parameter int START_DELAY   = 2,
  parameter int STOP_DELAY    = 2,
  parameter int DRAIN_TIMEOUT = 255,
  parameter int CNT_W         = 8
) (
  input  logic       clock,
  input  logic       async_reset,
  input  logic       node_request,
  input  logic       node_stopping,
  input  logic       peripheral_busy,
  output logic       clock_enable,
  output logic       started,
  output logic       stopped,
  output logic [2:0] responder_state,
  output logic       drain_timeout
);

  typedef enum logic [2:0] {
    OFF          = 3'b000,
    ENABLE_WAIT  = 3'b001,
    ON           = 3'b010,
    DRAIN        = 3'b011,
    DISABLE_WAIT = 3'b100
  } state_t;

  localparam logic [CNT_W-1:0] START_LOAD = CNT_W'(START_DELAY);
  localparam logic [CNT_W-1:0] STOP_LOAD  = CNT_W'(STOP_DELAY);
  localparam logic [CNT_W-1:0] DRAIN_LOAD = CNT_W'(DRAIN_TIMEOUT);

  state_t           state;
  logic [CNT_W-1:0] count;

  assign responder_state = state;

  always_ff @(posedge clock or posedge async_reset) begin
    if (async_reset) begin
      state        <= OFF;
      count        <= '0;
      clock_enable <= 1'b0;
      started      <= 1'b0;
      stopped      <= 1'b0;
`ifdef PERIPHERAL_CLOCK_RESPONDER_DRAIN_TIMEOUT_EN
      drain_timeout <= 1'b0;
`endif
    end else begin
      started <= 1'b0;
      stopped <= 1'b0;
      case (state)
        OFF: begin
          // The node keeps requesting until it sees stopped, so the pulse cycle must not restart.
          if (node_request && !stopped) begin
            state        <= ENABLE_WAIT;
            count        <= START_LOAD;
            clock_enable <= 1'b1;
          end
        end
        ENABLE_WAIT: begin
          if (count == '0) begin
            state   <= ON;
            started <= 1'b1;
          end else begin
            count <= count - 1'b1;
          end
        end
        ON: begin
          if (node_stopping) begin
            state <= DRAIN;
            count <= DRAIN_LOAD;
          end
        end
        DRAIN: begin
          if (!peripheral_busy) begin
            state        <= DISABLE_WAIT;
            count        <= STOP_LOAD;
            clock_enable <= 1'b0;
          end
`ifdef PERIPHERAL_CLOCK_RESPONDER_DRAIN_TIMEOUT_EN
          else if (count == '0) begin
            state         <= DISABLE_WAIT;
            count         <= STOP_LOAD;
            clock_enable  <= 1'b0;
            drain_timeout <= 1'b1;
          end else begin
            count <= count - 1'b1;
          end
`endif
        end
        DISABLE_WAIT: begin
          if (count == '0) begin
            state   <= OFF;
            stopped <= 1'b1;
          end else begin
            count <= count - 1'b1;
          end
        end
        default: begin
          state        <= OFF;
          count        <= '0;
          clock_enable <= 1'b0;
        end
      endcase
    end
  end

`ifndef PERIPHERAL_CLOCK_RESPONDER_DRAIN_TIMEOUT_EN
  assign drain_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_peripheral_clock_responder.sv
// tb/tb_peripheral_clock_responder.sv - directed self-checking bench for peripheral_clock_responder
module tb_peripheral_clock_responder;

  logic       clock;
  logic       async_reset;
  logic       node_request;
  logic       node_stopping;
  logic       peripheral_busy;
  logic       clock_enable;
  logic       started;
  logic       stopped;
  logic [2:0] responder_state;
  logic       drain_timeout;

  int checks;
  int failures;

  peripheral_clock_responder #(
    .START_DELAY  (3),
    .STOP_DELAY   (2),
    .DRAIN_TIMEOUT(8),
    .CNT_W        (8)
  ) dut (
    .clock          (clock),
    .async_reset    (async_reset),
    .node_request   (node_request),
    .node_stopping  (node_stopping),
    .peripheral_busy(peripheral_busy),
    .clock_enable   (clock_enable),
    .started        (started),
    .stopped        (stopped),
    .responder_state(responder_state),
    .drain_timeout  (drain_timeout)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    async_reset     = 1'b1;
    node_request    = 1'b0;
    node_stopping   = 1'b0;
    peripheral_busy = 1'b0;
    #2;
    checks++;
    if ({responder_state, clock_enable, started, stopped, drain_timeout} !== 7'b000_0000) begin
      failures++;
      $display("FAIL reset_state: got state=%0d ce=%0b st=%0b sp=%0b dt=%0b, want all 0",
               responder_state, clock_enable, started, stopped, drain_timeout);
    end
    tick();
    tick();
    async_reset = 1'b0;
  endtask

  // Request held one cycle then dropped: the start sequence must still complete.
  task automatic test_start();
    node_request = 1'b1;
    tick();
    node_request = 1'b0;
    checks++;
    if (responder_state !== 3'd1 || clock_enable !== 1'b1 || started !== 1'b0) begin
      failures++;
      $display("FAIL start_enter: got state=%0d ce=%0b st=%0b, want 1 1 0",
               responder_state, clock_enable, started);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (responder_state !== 3'd1 || started !== 1'b0) begin
        failures++;
        $display("FAIL start_wait%0d: got state=%0d st=%0b, want 1 0", i, responder_state, started);
      end
    end
    tick();
    checks++;
    if (responder_state !== 3'd2 || started !== 1'b1 || clock_enable !== 1'b1) begin
      failures++;
      $display("FAIL start_pulse: got state=%0d st=%0b ce=%0b, want 2 1 1",
               responder_state, started, clock_enable);
    end
    tick();
    checks++;
    if (responder_state !== 3'd2 || started !== 1'b0) begin
      failures++;
      $display("FAIL start_single: got state=%0d st=%0b, want 2 0", responder_state, started);
    end
  endtask

  // Stop with idle peripheral, then the node still requests on the stopped cycle.
  task automatic test_stop_and_restart();
    node_stopping = 1'b1;
    tick();
    node_stopping = 1'b0;
    checks++;
    if (responder_state !== 3'd3 || clock_enable !== 1'b1) begin
      failures++;
      $display("FAIL stop_drain: got state=%0d ce=%0b, want 3 1", responder_state, clock_enable);
    end
    tick();
    checks++;
    if (responder_state !== 3'd4 || clock_enable !== 1'b0) begin
      failures++;
      $display("FAIL stop_disable: got state=%0d ce=%0b, want 4 0", responder_state, clock_enable);
    end
    tick();
    tick();
    node_request = 1'b1;
    checks++;
    if (responder_state !== 3'd4 || stopped !== 1'b0) begin
      failures++;
      $display("FAIL stop_wait: got state=%0d sp=%0b, want 4 0", responder_state, stopped);
    end
    tick();
    checks++;
    if (responder_state !== 3'd0 || stopped !== 1'b1 || started !== 1'b0) begin
      failures++;
      $display("FAIL stop_pulse: got state=%0d sp=%0b st=%0b, want 0 1 0",
               responder_state, stopped, started);
    end
    tick();
    node_request = 1'b0;
    checks++;
    if (responder_state !== 3'd0 || stopped !== 1'b0 || clock_enable !== 1'b0) begin
      failures++;
      $display("FAIL no_restart: got state=%0d sp=%0b ce=%0b, want 0 0 0",
               responder_state, stopped, clock_enable);
    end
    tick();
    node_request = 1'b1;
    tick();
    checks++;
    if (responder_state !== 3'd1 || clock_enable !== 1'b1) begin
      failures++;
      $display("FAIL restart_enter: got state=%0d ce=%0b, want 1 1", responder_state, clock_enable);
    end
    tick();
    tick();
    tick();
    tick();
    checks++;
    if (responder_state !== 3'd2 || started !== 1'b1) begin
      failures++;
      $display("FAIL restart_on: got state=%0d st=%0b, want 2 1", responder_state, started);
    end
  endtask

  // Busy peripheral for 20 cycles; ignored node_stopping while draining.
  task automatic test_drain_busy();
    node_request    = 1'b0;
    peripheral_busy = 1'b1;
    node_stopping   = 1'b1;
    tick();
    checks++;
    if (responder_state !== 3'd3) begin
      failures++;
      $display("FAIL drain_enter: got state=%0d, want 3", responder_state);
    end
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (i == 8) begin
        checks++;
        if (responder_state !== 3'd3 || drain_timeout !== 1'b0) begin
          failures++;
          $display("FAIL drain_hold: got state=%0d dt=%0b, want 3 0", responder_state, drain_timeout);
        end
      end
`ifdef PERIPHERAL_CLOCK_RESPONDER_DRAIN_TIMEOUT_EN
      if (i == 9) begin
        checks++;
        if (responder_state !== 3'd4 || drain_timeout !== 1'b1 || clock_enable !== 1'b0) begin
          failures++;
          $display("FAIL drain_timeout: got state=%0d dt=%0b ce=%0b, want 4 1 0",
                   responder_state, drain_timeout, clock_enable);
        end
      end
`endif
    end
    node_stopping = 1'b0;
`ifdef PERIPHERAL_CLOCK_RESPONDER_DRAIN_TIMEOUT_EN
    checks++;
    if (responder_state !== 3'd0 || drain_timeout !== 1'b1) begin
      failures++;
      $display("FAIL drain_sticky: got state=%0d dt=%0b, want 0 1", responder_state, drain_timeout);
    end
    peripheral_busy = 1'b0;
`else
    checks++;
    if (responder_state !== 3'd3 || drain_timeout !== 1'b0 || clock_enable !== 1'b1) begin
      failures++;
      $display("FAIL drain_indef: got state=%0d dt=%0b ce=%0b, want 3 0 1",
               responder_state, drain_timeout, clock_enable);
    end
    peripheral_busy = 1'b0;
    tick();
    tick();
    tick();
    tick();
    checks++;
    if (responder_state !== 3'd0 || stopped !== 1'b1) begin
      failures++;
      $display("FAIL drain_release: got state=%0d sp=%0b, want 0 1", responder_state, stopped);
    end
`endif
    tick();
  endtask

  // Reset asserted between edges while ENABLE_WAIT counter is 2.
  task automatic test_reset_mid_sequence();
    node_request = 1'b1;
    tick();
    node_request = 1'b0;
    tick();
    #2;
    async_reset = 1'b1;
    #1;
    checks++;
    if (responder_state !== 3'd0 || clock_enable !== 1'b0 || drain_timeout !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid: got state=%0d ce=%0b dt=%0b, want 0 0 0",
               responder_state, clock_enable, drain_timeout);
    end
    tick();
    async_reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (started !== 1'b0 || responder_state !== 3'd0) begin
        failures++;
        $display("FAIL reset_no_pulse%0d: got st=%0b state=%0d, want 0 0", i, started, responder_state);
      end
    end
    node_request = 1'b1;
    tick();
    node_request = 1'b0;
    tick();
    tick();
    tick();
    checks++;
    if (responder_state !== 3'd1 || started !== 1'b0) begin
      failures++;
      $display("FAIL reset_restart_wait: got state=%0d st=%0b, want 1 0", responder_state, started);
    end
    tick();
    checks++;
    if (responder_state !== 3'd2 || started !== 1'b1) begin
      failures++;
      $display("FAIL reset_restart_on: got state=%0d st=%0b, want 2 1", responder_state, started);
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_start();
    test_stop_and_restart();
    test_drain_busy();
    test_reset_mid_sequence();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
